// File: rtl/vga_hex_pkg.sv
// Shared types and helpers for the hex word plotter: FSM state encoding,
// glyph geometry and the glyph ROM address packing.
package vga_hex_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    PLOT,
    DONE
  } state_e;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;

  function automatic logic [6:0] rom_addr(input logic [3:0] digit, input logic [2:0] row);
    return {digit, row};
  endfunction

endpackage

// File: rtl/hex_word_plotter_glyph_row_serialiser.sv
// Loads one 8-bit glyph row and walks it out column 0..7, one bit per cycle.
// Exposes next-cycle bit/column so the parent can register its pixel outputs.
module glyph_row_serialiser
  import vga_hex_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [GLYPH_W-1:0] row_in,
  output logic               nxt_valid,
  output logic               nxt_bit,
  output logic [2:0]         nxt_col,
  output logic               done
);

  logic [GLYPH_W-1:0] shreg_q, shreg_d;
  logic [2:0]         col_q, col_d;
  logic               valid_q, valid_d;

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    shreg_d = shreg_q;
    col_d   = col_q;
    valid_d = valid_q;
    if (load) begin
      shreg_d = row_in;
      col_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q) begin
      shreg_d = shreg_q >> 1;
      col_d   = col_q + 3'd1;
      valid_d = (col_q != 3'(GLYPH_W - 1));
    end
  end

  assign nxt_valid = valid_d;
  assign nxt_bit   = shreg_d[0];
  assign nxt_col   = col_d;
  assign done      = valid_q && (col_q == 3'(GLYPH_W - 1));

  // NOTE: state flops use non-blocking assignments; reset is synchronous, so it is tested inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      col_q   <= col_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/hex_word_plotter.sv
// Draws a DATA_W-bit word as DATA_W/4 8x8 hex glyphs through the VGA pixel port,
// MS digit leftmost, using an external glyph ROM and an enable/acknowledge handshake.
module hex_word_plotter
  import vga_hex_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOUR_W    = 3,
  parameter int ROM_LATENCY = 2,
  parameter int LZ_BLANK    = 0
) (
  input  logic                CLOCK_50,
  input  logic                resetIn,
  input  logic                enable,
  output logic                acknowledge,
  input  logic [DATA_W-1:0]   data,
  input  logic [X_W-1:0]      x_origin,
  input  logic [Y_W-1:0]      y_origin,
  input  logic [COLOUR_W-1:0] fg_colour,
  input  logic [COLOUR_W-1:0] bg_colour,
  input  logic                transparent,
  output logic [6:0]          rom_address,
  input  logic [7:0]          rom_data,
  output logic [X_W-1:0]      xOut,
  output logic [Y_W-1:0]      yOut,
  output logic [COLOUR_W-1:0] colorOut,
  output logic                writeEnable
);

  localparam int         NUM_DIGITS = DATA_W / 4;
  localparam logic [3:0] LAST_DIGIT = 4'(NUM_DIGITS - 1);
  localparam logic [1:0] LAST_WAIT  = 2'(ROM_LATENCY - 1);

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     word_q, word_d;
  logic [3:0]            digit_q, digit_d;
  logic [2:0]            row_q, row_d;
  logic [1:0]            wait_q, wait_d;
  logic [X_W-1:0]        x_base_q, x_base_d;
  logic [Y_W-1:0]        y_org_q, y_org_d;
  logic [COLOUR_W-1:0]   fg_q, fg_d, bg_q, bg_d;
  logic                  transp_q, transp_d;
  logic                  blank_q, blank_d;
  logic                  ser_load;

  logic                  we_q, we_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [COLOUR_W-1:0]   colour_q, colour_d;

  logic                  nxt_valid, nxt_bit, ser_done, pix_bit;
  logic [2:0]            nxt_col;

  glyph_row_serialiser u_ser (
    .clk      (CLOCK_50),
    .rst_n    (resetIn),
    .load     (ser_load),
    .row_in   (rom_data),
    .nxt_valid(nxt_valid),
    .nxt_bit  (nxt_bit),
    .nxt_col  (nxt_col),
    .done     (ser_done)
  );

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    digit_d  = digit_q;
    row_d    = row_q;
    wait_d   = wait_q;
    x_base_d = x_base_q;
    y_org_d  = y_org_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    transp_d = transp_q;
    blank_d  = blank_q;
    ser_load = 1'b0;
    case (state_q)
      IDLE: if (enable) state_d = LOAD;
      LOAD: begin
        word_d   = data;
        x_base_d = x_origin;
        y_org_d  = y_origin;
        fg_d     = fg_colour;
        bg_d     = bg_colour;
        transp_d = transparent;
        digit_d  = '0;
        row_d    = '0;
        wait_d   = '0;
        blank_d  = (LZ_BLANK != 0) && (NUM_DIGITS > 1) && (data[DATA_W-1 -: 4] == 4'd0);
        state_d  = FETCH;
      end
      FETCH: begin
        if (wait_q == LAST_WAIT) begin
          ser_load = 1'b1;
          state_d  = PLOT;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      PLOT: begin
        if (ser_done) begin
          wait_d = '0;
          if (row_q != 3'(GLYPH_H - 1)) begin
            row_d   = row_q + 3'd1;
            state_d = FETCH;
          end else if (digit_q != LAST_DIGIT) begin
            digit_d  = digit_q + 4'd1;
            row_d    = '0;
            word_d   = word_q << 4;
            x_base_d = x_base_q + X_W'(GLYPH_W);
            // Blanking persists only while every digit so far has been zero.
            blank_d  = blank_q && (word_d[DATA_W-1 -: 4] == 4'd0) && (digit_d != LAST_DIGIT);
            state_d  = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel outputs are registered from the serialiser's next-cycle view,
  // so writeEnable lines up exactly with the PLOT cycles.
  always_comb begin
    pix_bit  = nxt_bit & ~blank_q;
    we_d     = nxt_valid & (pix_bit | ~transp_q);
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    if (nxt_valid) begin
      x_d      = x_base_q + X_W'(nxt_col);
      y_d      = y_org_q + Y_W'(row_q);
      colour_d = pix_bit ? fg_q : bg_q;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetIn) begin
      state_q  <= IDLE;
      word_q   <= '0;
      digit_q  <= '0;
      row_q    <= '0;
      wait_q   <= '0;
      x_base_q <= '0;
      y_org_q  <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      transp_q <= 1'b0;
      blank_q  <= 1'b0;
      we_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      digit_q  <= digit_d;
      row_q    <= row_d;
      wait_q   <= wait_d;
      x_base_q <= x_base_d;
      y_org_q  <= y_org_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      transp_q <= transp_d;
      blank_q  <= blank_d;
      we_q     <= we_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

  assign rom_address = rom_addr(word_q[DATA_W-1 -: 4], row_q);
  assign acknowledge = (state_q == DONE);
  assign writeEnable = we_q;
  assign xOut        = x_q;
  assign yOut        = y_q;
  assign colorOut    = colour_q;

endmodule

// File: tb/tb_hex_word_plotter.sv
// Self-checking bench: three plotter configurations against a pixel-list reference model
// built directly from the glyph table, with a registered glyph ROM model per instance.
module tb_hex_word_plotter;

  localparam int ROM_LAT = 2;
  localparam int ND      = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [ND-1:0] en;
  logic [31:0]   data;
  logic [7:0]    xo;
  logic [6:0]    yo;
  logic [2:0]    fg, bg;
  logic          transp;

  logic       ack   [ND];
  logic       we    [ND];
  logic [6:0] addr  [ND];
  logic [7:0] rdata [ND];
  logic [7:0] xout  [ND];
  logic [6:0] yout  [ND];
  logic [2:0] cout  [ND];

  logic [7:0] glyph [16][8];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {int x; int y; int c;} pix_t;
  pix_t exp_q[$];

  // Instance 0: 32-bit word; instance 1: 8-bit word; instance 2: 32-bit with leading-zero blanking.
  hex_word_plotter #(.DATA_W(32), .ROM_LATENCY(ROM_LAT), .LZ_BLANK(0)) u_dut0 (
    .CLOCK_50(clk), .resetIn(rst_n), .enable(en[0]), .acknowledge(ack[0]), .data(data),
    .x_origin(xo), .y_origin(yo), .fg_colour(fg), .bg_colour(bg), .transparent(transp),
    .rom_address(addr[0]), .rom_data(rdata[0]), .xOut(xout[0]), .yOut(yout[0]),
    .colorOut(cout[0]), .writeEnable(we[0]));

  hex_word_plotter #(.DATA_W(8), .ROM_LATENCY(ROM_LAT), .LZ_BLANK(0)) u_dut1 (
    .CLOCK_50(clk), .resetIn(rst_n), .enable(en[1]), .acknowledge(ack[1]), .data(data[7:0]),
    .x_origin(xo), .y_origin(yo), .fg_colour(fg), .bg_colour(bg), .transparent(transp),
    .rom_address(addr[1]), .rom_data(rdata[1]), .xOut(xout[1]), .yOut(yout[1]),
    .colorOut(cout[1]), .writeEnable(we[1]));

  hex_word_plotter #(.DATA_W(32), .ROM_LATENCY(ROM_LAT), .LZ_BLANK(1)) u_dut2 (
    .CLOCK_50(clk), .resetIn(rst_n), .enable(en[2]), .acknowledge(ack[2]), .data(data),
    .x_origin(xo), .y_origin(yo), .fg_colour(fg), .bg_colour(bg), .transparent(transp),
    .rom_address(addr[2]), .rom_data(rdata[2]), .xOut(xout[2]), .yOut(yout[2]),
    .colorOut(cout[2]), .writeEnable(we[2]));

  // Glyph ROM with ROM_LAT = 2: one register between address and data.
  always @(posedge clk) begin
    for (int i = 0; i < ND; i++) rdata[i] <= glyph[addr[i][6:3]][addr[i][2:0]];
  end

  task automatic check(input string tag, input longint obs, input longint exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference: every pixel the word should produce, in drawing order.
  task automatic build(input int ndig, input logic [31:0] d, input int x0, input int y0,
                       input int f, input int b, input bit tr, input bit lz);
    longint w;
    exp_q.delete();
    w = longint'(d) & ((64'd1 << (4 * ndig)) - 1);
    for (int k = 0; k < ndig; k++) begin
      int  sh    = 4 * (ndig - 1 - k);
      int  nib   = int'((w >> sh) & 15);
      bit  blank = lz && (k < ndig - 1) && ((w >> sh) == 0);
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          bit px = glyph[nib][r][c] && !blank;
          if (px || !tr) exp_q.push_back('{(x0 + 8 * k + c) % 256, (y0 + r) % 128, px ? f : b});
        end
      end
    end
  endtask

  task automatic set_inputs(input logic [31:0] d, input int x0, input int y0,
                            input int f, input int b, input bit tr);
    data   = d;
    xo     = 8'(x0);
    yo     = 7'(y0);
    fg     = 3'(f);
    bg     = 3'(b);
    transp = tr;
  endtask

  // Raise enable, check every write against the model, stop at acknowledge (enable left high).
  task automatic draw(input int idx, input int ndig, input string tag);
    int   cycles = 0;
    int   nw     = 0;
    int   exp_n  = exp_q.size();
    bit   got    = 1'b0;
    pix_t p;
    @(posedge clk);
    #1 en[idx] = 1'b1;
    while (!got && cycles < 3000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (cycles == 2) begin
        data   = $urandom;
        xo     = 8'($urandom);
        yo     = 7'($urandom);
        fg     = 3'($urandom);
        bg     = 3'($urandom);
        transp = 1'($urandom);
      end
      if (we[idx]) begin
        nw++;
        if (exp_q.size() == 0) begin
          check({tag, " extra write"}, 1, 0);
        end else begin
          p = exp_q.pop_front();
          check({tag, " x"}, xout[idx], p.x);
          check({tag, " y"}, yout[idx], p.y);
          check({tag, " colour"}, cout[idx], p.c);
        end
      end
      if (ack[idx]) got = 1'b1;
    end
    check({tag, " ack latency"}, cycles, 2 + ndig * 8 * (ROM_LAT + 8));
    check({tag, " write count"}, nw, exp_n);
  endtask

  task automatic release_hs(input int idx, input string tag);
    en[idx] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " ack drop"}, ack[idx], 0);
  endtask

  initial begin
    int idx, nd, bad_ack, bad_we;
    logic [31:0] d;
    rst_n  = 1'b0;
    en     = '0;
    set_inputs(32'h0, 0, 0, 0, 0, 1'b0);
    for (int n = 0; n < 16; n++)
      for (int r = 0; r < 8; r++) glyph[n][r] = 8'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset we",   we[0],   0);
    check("reset ack",  ack[0],  0);
    check("reset x",    xout[0], 0);
    check("reset y",    yout[0], 0);
    check("reset col",  cout[0], 0);
    check("reset addr", addr[0], 0);
    rst_n = 1'b1;

    set_inputs(32'h0000_0001, 0, 0, 7, 0, 1'b0);
    build(8, 32'h0000_0001, 0, 0, 7, 0, 1'b0, 1'b0);
    draw(0, 8, "opaque_one");
    release_hs(0, "opaque_one");

    set_inputs(32'h8888_8888, 10, 20, 3, 4, 1'b1);
    build(8, 32'h8888_8888, 10, 20, 3, 4, 1'b1, 1'b0);
    check("transparent expected count", exp_q.size(), 8 * $countones(glyph[8][0]) +
          8 * ($countones(glyph[8][1]) + $countones(glyph[8][2]) + $countones(glyph[8][3]) +
               $countones(glyph[8][4]) + $countones(glyph[8][5]) + $countones(glyph[8][6]) +
               $countones(glyph[8][7])));
    draw(0, 8, "transparent_8s");
    release_hs(0, "transparent_8s");

    set_inputs(32'h0000_00AB, 250, 5, 6, 1, 1'b0);
    build(2, 32'h0000_00AB, 250, 5, 6, 1, 1'b0, 1'b0);
    draw(1, 2, "x_wrap");
    release_hs(1, "x_wrap");

    set_inputs(32'h0, 3, 100, 5, 2, 1'b0);
    build(8, 32'h0, 3, 100, 5, 2, 1'b0, 1'b1);
    draw(2, 8, "lz_blank_zero");
    release_hs(2, "lz_blank_zero");

    for (int t = 0; t < 6; t++) begin
      idx = $urandom_range(0, 2);
      nd  = (idx == 1) ? 2 : 8;
      d   = $urandom;
      if (idx == 2) d = d >> $urandom_range(0, 31);
      set_inputs(d, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom));
      build(nd, d, int'(xo), int'(yo), int'(fg), int'(bg), transp, idx == 2);
      draw(idx, nd, "random");
      release_hs(idx, "random");
    end

    // Enable held after acknowledge: acknowledge stays, nothing is redrawn.
    set_inputs(32'h1234_5678, 40, 30, 7, 1, 1'b0);
    build(8, 32'h1234_5678, 40, 30, 7, 1, 1'b0, 1'b0);
    draw(0, 8, "hold");
    bad_ack = 0;
    bad_we  = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (!ack[0]) bad_ack++;
      if (we[0]) bad_we++;
    end
    check("hold ack low cycles", bad_ack, 0);
    check("hold redraw writes", bad_we, 0);
    release_hs(0, "hold");
    set_inputs(32'hCAFE_F00D, 0, 64, 2, 5, 1'b1);
    build(8, 32'hCAFE_F00D, 0, 64, 2, 5, 1'b1, 1'b0);
    draw(0, 8, "reraise");
    release_hs(0, "reraise");

    // Reset in the middle of a PLOT row aborts the draw.
    set_inputs(32'hFFFF_FFFF, 0, 0, 7, 3, 1'b0);
    @(posedge clk);
    #1 en[0] = 1'b1;
    repeat (105) @(posedge clk);
    @(negedge clk);
    check("mid-plot we before reset", we[0], 1);
    rst_n = 1'b0;
    en[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset abort we", we[0], 0);
    check("reset abort ack", ack[0], 0);
    rst_n   = 1'b1;
    bad_we  = 0;
    bad_ack = 0;
    repeat (700) begin
      @(posedge clk);
      @(negedge clk);
      if (we[0]) bad_we++;
      if (ack[0]) bad_ack++;
    end
    check("writes after reset", bad_we, 0);
    check("ack after reset", bad_ack, 0);

    set_inputs(32'h0BAD_BEEF, 200, 120, 4, 6, 1'b0);
    build(8, 32'h0BAD_BEEF, 200, 120, 4, 6, 1'b0, 1'b0);
    draw(0, 8, "after_reset");
    release_hs(0, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
